// File: rtl/bpu_update_sched_pkg.sv
// bpu_update_sched_pkg: branch-type codes, update-queue entry and FSM states
// shared by the BPU update scheduler and its queue.
package bpu_update_sched_pkg;

   localparam int UQ_DEPTH_DEF = 8;
   localparam int PC_W         = 32;

   localparam logic [2:0] BR_COND = 3'd1;
   localparam logic [2:0] BR_CALL = 3'd2;
   localparam logic [2:0] BR_RET  = 3'd3;
   localparam logic [2:0] BR_JMP  = 3'd4;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] target;
      logic [2:0]      br_type;
      logic            taken;
      logic            miss;
   } uq_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RELOAD = 2'd2
   } upd_state_e;

endpackage

// File: rtl/bpu_upd_fifo.sv
// bpu_upd_fifo: 4-in/1-out compacting update queue with free-entry count.
// Pushed lanes land in consecutive slots in lane order.
module bpu_upd_fifo
   import bpu_update_sched_pkg::*;
#(
   parameter int DEPTH = UQ_DEPTH_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [3:0]               push_i,
   input  uq_entry_t                din_i [4],
   input  logic                     pop_i,
   output uq_entry_t                head_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   free_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEP = (AW+1)'(DEPTH);

   uq_entry_t   mem_q [DEPTH];
   logic [AW:0] wr_q, rd_q, cnt, npush;
   logic [AW:0] off [4];
   logic [AW-1:0] idx [4];
   logic        full;

   // Each pushed lane's slot offset is the number of pushed lanes below it.
   always_comb begin
      off[0] = '0;
      for (int l = 1; l < 4; l++)
         off[l] = off[l-1] + {{AW{1'b0}}, push_i[l-1]};
      for (int l = 0; l < 4; l++)
         idx[l] = wr_q[AW-1:0] + off[l][AW-1:0];
      npush = off[3] + {{AW{1'b0}}, push_i[3]};
   end

   always_ff @(posedge clk_i) begin
      for (int l = 0; l < 4; l++)
         if (push_i[l]) mem_q[idx[l]] <= din_i[l];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_q + npush;
         rd_q <= rd_q + {{AW{1'b0}}, pop_i};
      end
   end

   assign cnt     = wr_q - rd_q;
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (cnt == '0);
   assign free_o  = DEP - cnt;
   assign head_o  = mem_q[rd_q[AW-1:0]];

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(full && |push_i));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(empty_o && pop_i));

endmodule

// File: rtl/bpu_update_sched.sv
// bpu_update_sched: serializes retired-branch training into BTB/TAGE and
// sequences RAS/GHR reload. Optional BPU_UPD_PERF_EN adds perf counters.
module bpu_update_sched
   import bpu_update_sched_pkg::*;
#(
   parameter int UQ_DEPTH = UQ_DEPTH_DEF,
   parameter int GHR_W    = 64
) (
   input  logic              Clk,
   input  logic              Rest,
   input  logic [3:0]        CmtValid,
   input  logic [3:0]        CmtIsBr,
   input  logic [3:0]        CmtTaken,
   input  logic [3:0]        CmtMiss,
   input  logic [4*PC_W-1:0] CmtPc,
   input  logic [4*PC_W-1:0] CmtTarget,
   input  logic [4*3-1:0]    CmtType,
   input  logic [GHR_W-1:0]  CmtGHR,
   input  logic [3:0]        CmtRasPtr,
   output logic              CmtReady,
   input  logic              BpuUpBusy,
   output logic              UpBtbAble,
   output logic [PC_W-1:0]   UpBtbPc,
   output logic [PC_W-1:0]   UpBtbTaget,
   output logic [2:0]        UpBtbType,
   output logic              UpTageAble,
   output logic [PC_W-1:0]   UpTagePc,
   output logic              UpTageTaken,
   output logic              UpTageReLoad,
   output logic [GHR_W-1:0]  UpTageGHR,
   output logic              UpRasReLoad,
   output logic [3:0]        UpRasPtr
`ifdef BPU_UPD_PERF_EN
  ,output logic [31:0]       PerfUpdCnt,
   output logic [31:0]       PerfMissCnt
`endif
);

   localparam int AW = $clog2(UQ_DEPTH);
   localparam logic [AW:0] LANES = (AW+1)'(4);

   upd_state_e       state_q;
   logic [GHR_W-1:0] ghr_q;
   logic [3:0]       ras_q;
   uq_entry_t        lane_ent [4];
   uq_entry_t        head;
   logic [3:0]       keep, push;
   logic             cut, empty, pop, reload, snap_load;
   logic [AW:0]      free;

   // Lanes younger than the oldest mispredict are flushed by the ROB.
   always_comb begin
      keep = '0;
      cut  = 1'b0;
      for (int l = 0; l < 4; l++) begin
         keep[l] = !cut;
         if (CmtValid[l] && CmtMiss[l]) cut = 1'b1;
         lane_ent[l] = '{pc:      CmtPc[l*PC_W +: PC_W],
                         target:  CmtTarget[l*PC_W +: PC_W],
                         br_type: CmtType[l*3 +: 3],
                         taken:   CmtTaken[l],
                         miss:    CmtMiss[l]};
      end
      push = CmtValid & CmtIsBr & keep & {4{CmtReady}};
   end

   assign snap_load = |(push & CmtMiss);

   bpu_upd_fifo #(.DEPTH(UQ_DEPTH)) u_fifo (
      .clk_i   (Clk),
      .rst_ni  (Rest),
      .push_i  (push),
      .din_i   (lane_ent),
      .pop_i   (pop),
      .head_o  (head),
      .empty_o (empty),
      .free_o  (free)
   );

   assign CmtReady = (free >= LANES);
   assign reload   = (state_q == ST_RELOAD);
   assign pop      = !empty && !BpuUpBusy && !reload;

   assign UpBtbAble    = pop && (head.taken || head.miss);
   assign UpTageAble   = pop && (head.br_type == BR_COND);
   assign UpBtbPc      = pop ? head.pc : '0;
   assign UpBtbTaget   = pop ? head.target : '0;
   assign UpBtbType    = pop ? head.br_type : '0;
   assign UpTagePc     = pop ? head.pc : '0;
   assign UpTageTaken  = pop && head.taken;
   assign UpTageReLoad = reload;
   assign UpRasReLoad  = reload;
   assign UpTageGHR    = reload ? ghr_q : '0;
   assign UpRasPtr     = reload ? ras_q : '0;

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         state_q <= ST_IDLE;
         ghr_q   <= '0;
         ras_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_ISSUE: begin
               if (pop && head.miss) state_q <= ST_RELOAD;
               else if (!empty)      state_q <= ST_ISSUE;
               else                  state_q <= ST_IDLE;
            end
            ST_RELOAD: begin
               ghr_q   <= '0;
               ras_q   <= '0;
               state_q <= empty ? ST_IDLE : ST_ISSUE;
            end
            default: state_q <= ST_IDLE;
         endcase
         if (snap_load) begin
            ghr_q <= CmtGHR;
            ras_q <= CmtRasPtr;
         end
      end
   end

   a_cmt_ready: assert property (@(posedge Clk) disable iff (!Rest)
      !(|CmtValid && !CmtReady));

`ifdef BPU_UPD_PERF_EN
   logic [31:0] perf_upd_q, perf_miss_q;

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         perf_upd_q  <= '0;
         perf_miss_q <= '0;
      end else begin
         if ((UpBtbAble || UpTageAble) && perf_upd_q != '1)
            perf_upd_q <= perf_upd_q + 32'd1;
         if (reload && perf_miss_q != '1)
            perf_miss_q <= perf_miss_q + 32'd1;
      end
   end

   assign PerfUpdCnt  = perf_upd_q;
   assign PerfMissCnt = perf_miss_q;
`endif

endmodule

// File: tb/tb_bpu_update_sched.sv
// tb_bpu_update_sched: table-driven directed checks of the BPU update
// scheduler plus a hand-written reset-during-reload sequence.
module tb_bpu_update_sched;
   import bpu_update_sched_pkg::*;

   logic         Clk = 1'b0;
   logic         Rest;
   logic [3:0]   CmtValid, CmtIsBr, CmtTaken, CmtMiss, CmtRasPtr;
   logic [127:0] CmtPc, CmtTarget;
   logic [11:0]  CmtType;
   logic [63:0]  CmtGHR;
   logic         CmtReady, BpuUpBusy;
   logic         UpBtbAble, UpTageAble, UpTageTaken;
   logic         UpTageReLoad, UpRasReLoad;
   logic [31:0]  UpBtbPc, UpBtbTaget, UpTagePc;
   logic [2:0]   UpBtbType;
   logic [63:0]  UpTageGHR;
   logic [3:0]   UpRasPtr;
`ifdef BPU_UPD_PERF_EN
   logic [31:0]  PerfUpdCnt, PerfMissCnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   bpu_update_sched dut (
      .Clk(Clk), .Rest(Rest),
      .CmtValid(CmtValid), .CmtIsBr(CmtIsBr), .CmtTaken(CmtTaken),
      .CmtMiss(CmtMiss), .CmtPc(CmtPc), .CmtTarget(CmtTarget),
      .CmtType(CmtType), .CmtGHR(CmtGHR), .CmtRasPtr(CmtRasPtr),
      .CmtReady(CmtReady), .BpuUpBusy(BpuUpBusy),
      .UpBtbAble(UpBtbAble), .UpBtbPc(UpBtbPc), .UpBtbTaget(UpBtbTaget),
      .UpBtbType(UpBtbType), .UpTageAble(UpTageAble), .UpTagePc(UpTagePc),
      .UpTageTaken(UpTageTaken), .UpTageReLoad(UpTageReLoad),
      .UpTageGHR(UpTageGHR), .UpRasReLoad(UpRasReLoad), .UpRasPtr(UpRasPtr)
`ifdef BPU_UPD_PERF_EN
     ,.PerfUpdCnt(PerfUpdCnt), .PerfMissCnt(PerfMissCnt)
`endif
   );

   typedef struct {
      string        name;
      logic [3:0]   v, br, tk, ms;
      logic [127:0] pc, tg;
      logic [11:0]  ty;
      logic [63:0]  ghr;
      logic [3:0]   ras;
      logic         busy;
      logic         ebtb, etage, etk, erl, erdy;
      logic [31:0]  epc, etg;
      logic [2:0]   ety;
      logic [63:0]  eghr;
      logic [3:0]   eras;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t nv(string name, bit busy = 1'b0, bit rdy = 1'b1);
      vec_t x;
      x = '{name: name, default: '0};
      x.busy = busy;
      x.erdy = rdy;
      return x;
   endfunction

   function automatic vec_t lane(vec_t x, int l, bit tk, bit ms,
                                 logic [31:0] pc, logic [31:0] tg,
                                 logic [2:0] ty);
      x.v[l]           = 1'b1;
      x.br[l]          = 1'b1;
      x.tk[l]          = tk;
      x.ms[l]          = ms;
      x.pc[l*32 +: 32] = pc;
      x.tg[l*32 +: 32] = tg;
      x.ty[l*3 +: 3]   = ty;
      return x;
   endfunction

   function automatic vec_t iss(vec_t x, bit btb, bit tage,
                                logic [31:0] pc, logic [31:0] tg,
                                bit tk, logic [2:0] ty);
      x.ebtb  = btb;
      x.etage = tage;
      x.epc   = pc;
      x.etg   = tg;
      x.etk   = tk;
      x.ety   = ty;
      return x;
   endfunction

   task automatic drive(input vec_t x);
      CmtValid  = x.v;
      CmtIsBr   = x.br;
      CmtTaken  = x.tk;
      CmtMiss   = x.ms;
      CmtPc     = x.pc;
      CmtTarget = x.tg;
      CmtType   = x.ty;
      CmtGHR    = x.ghr;
      CmtRasPtr = x.ras;
      BpuUpBusy = x.busy;
   endtask

   task automatic check(input vec_t x);
      logic [172:0] act, exp;
      act = {UpBtbAble, UpTageAble, UpBtbPc, UpTagePc, UpBtbTaget,
             UpBtbType, UpTageTaken, UpTageReLoad, UpRasReLoad,
             UpTageGHR, UpRasPtr, CmtReady};
      exp = {x.ebtb, x.etage, x.epc, x.epc, x.etg, x.ety, x.etk,
             x.erl, x.erl, x.eghr, x.eras, x.erdy};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", x.name, act, exp);
      end
   endtask

   initial begin
      vec_t v;
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      vec_t v;
      // single taken jump
      v = nv("b1_cmt"); v = lane(v, 0, 1, 0, 'h1000, 'h2000, BR_JMP); tbl.push_back(v);
      v = nv("b1_iss"); v = iss(v, 1, 0, 'h1000, 'h2000, 1, BR_JMP); tbl.push_back(v);
      tbl.push_back(nv("b1_idle"));
      // four not-taken conditionals
      v = nv("c4_cmt");
      for (int l = 0; l < 4; l++)
         v = lane(v, l, 0, 0, 32'h100 + 32'(4*l), 32'h200 + 32'(4*l), BR_COND);
      tbl.push_back(v);
      for (int l = 0; l < 4; l++) begin
         v = nv($sformatf("c4_iss%0d", l));
         v = iss(v, 0, 1, 32'h100 + 32'(4*l), 32'h200 + 32'(4*l), 0, BR_COND);
         tbl.push_back(v);
      end
      tbl.push_back(nv("c4_idle"));
      // lane-1 mispredict drops lanes 2-3
      v = nv("m_cmt");
      v = lane(v, 0, 1, 0, 'h300, 'h400, BR_COND);
      v = lane(v, 1, 0, 1, 'h304, 'h308, BR_COND);
      v = lane(v, 2, 1, 0, 'h30C, 'h500, BR_JMP);
      v = lane(v, 3, 1, 0, 'h310, 'h600, BR_JMP);
      v.ghr = 64'hDEAD_BEEF_0123_4567; v.ras = 4'd5;
      tbl.push_back(v);
      v = nv("m_iss0"); v = iss(v, 1, 1, 'h300, 'h400, 1, BR_COND); tbl.push_back(v);
      v = nv("m_iss1"); v = iss(v, 1, 1, 'h304, 'h308, 0, BR_COND); tbl.push_back(v);
      v = nv("m_reload"); v.erl = 1; v.eghr = 64'hDEAD_BEEF_0123_4567; v.eras = 4'd5;
      tbl.push_back(v);
      tbl.push_back(nv("m_idle"));
      tbl.push_back(nv("m_idle2"));
      // busy hold with three queued calls
      v = nv("bz_cmt", 1);
      for (int l = 0; l < 3; l++)
         v = lane(v, l, 1, 0, 32'h500 + 32'(4*l), 32'h600 + 32'(4*l), BR_CALL);
      tbl.push_back(v);
      for (int i = 0; i < 5; i++) tbl.push_back(nv($sformatf("bz_hold%0d", i), 1));
      for (int l = 0; l < 3; l++) begin
         v = nv($sformatf("bz_iss%0d", l));
         v = iss(v, 1, 0, 32'h500 + 32'(4*l), 32'h600 + 32'(4*l), 1, BR_CALL);
         tbl.push_back(v);
      end
      tbl.push_back(nv("bz_idle"));
      // fill to 8, then push/pop across the pointer wrap
      v = nv("f_cmt0", 1);
      for (int l = 0; l < 4; l++)
         v = lane(v, l, 1, 0, 32'h700 + 32'(4*l), 32'h800 + 32'(4*l), BR_RET);
      tbl.push_back(v);
      v = nv("f_cmt1", 1);
      for (int l = 0; l < 4; l++)
         v = lane(v, l, 1, 0, 32'h710 + 32'(4*l), 32'h810 + 32'(4*l), BR_RET);
      tbl.push_back(v);
      tbl.push_back(nv("f_full", 1, 0));
      for (int i = 0; i < 4; i++) begin
         v = nv($sformatf("f_iss%0d", i), 0, 0);
         v = iss(v, 1, 0, 32'h700 + 32'(4*i), 32'h800 + 32'(4*i), 1, BR_RET);
         tbl.push_back(v);
      end
      v = nv("f_wrap", 0, 1);
      v = iss(v, 1, 0, 'h710, 'h810, 1, BR_RET);
      v = lane(v, 0, 1, 0, 'h900, 'hA00, BR_JMP);
      v = lane(v, 1, 1, 0, 'h904, 'hA04, BR_JMP);
      tbl.push_back(v);
      v = nv("f_iss5", 0, 0); v = iss(v, 1, 0, 'h714, 'h814, 1, BR_RET); tbl.push_back(v);
      v = nv("f_iss6"); v = iss(v, 1, 0, 'h718, 'h818, 1, BR_RET); tbl.push_back(v);
      v = nv("f_iss7"); v = iss(v, 1, 0, 'h71C, 'h81C, 1, BR_RET); tbl.push_back(v);
      v = nv("f_iss8"); v = iss(v, 1, 0, 'h900, 'hA00, 1, BR_JMP); tbl.push_back(v);
      v = nv("f_iss9"); v = iss(v, 1, 0, 'h904, 'hA04, 1, BR_JMP); tbl.push_back(v);
      tbl.push_back(nv("f_idle"));
      // mispredict leading into reload, interrupted by reset
      v = nv("g_cmt"); v = lane(v, 0, 1, 1, 'hA00, 'hB00, BR_COND);
      v.ghr = 64'h1234; v.ras = 4'd9;
      tbl.push_back(v);
      v = nv("g_iss"); v = iss(v, 1, 1, 'hA00, 'hB00, 1, BR_COND); tbl.push_back(v);
      v = nv("g_reload"); v.erl = 1; v.eghr = 64'h1234; v.eras = 4'd9;
      tbl.push_back(v);

      Rest = 1'b0;
      drive(nv("rst"));
      #1;
      check(nv("reset"));
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Rest = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge Clk); #1;
         drive(tbl[i]);
         @(negedge Clk);
         check(tbl[i]);
      end

      #1;
      Rest = 1'b0;
      drive(nv("rst"));
      #1;
      check(nv("g_rst_out"));
      checks++;
      if (dut.state_q !== ST_IDLE) begin
         errors++;
         $display("FAIL g_rst_fsm: got %0d want %0d", dut.state_q, ST_IDLE);
      end
`ifdef BPU_UPD_PERF_EN
      checks++;
      if (PerfUpdCnt !== 32'd0 || PerfMissCnt !== 32'd0) begin
         errors++;
         $display("FAIL g_rst_perf: got %0d/%0d want 0/0", PerfUpdCnt, PerfMissCnt);
      end
`endif
      @(posedge Clk); #1;
      Rest = 1'b1;
      @(negedge Clk);
      check(nv("g_post_idle"));
      @(posedge Clk); #1;
      @(negedge Clk);
      check(nv("g_post_idle2"));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
